// File: rtl/quadrature_decoder.sv
// quadrature_decoder
// Front end for the 3-bit up/down counter. Synchronizes the two encoder
// phases, optionally debounces them, and turns every legal Gray-code move
// into a one-cycle step pulse plus a direction level. Double-bit moves are
// flagged on err and counted in a saturating 4-bit counter.
//
// Optional feature: define QDEC_GLITCH_FILTER_EN to add a per-phase
// stability filter. A new level is then accepted only after FILTER_LEN
// consecutive identical samples at the synchronizer output.

module quadrature_decoder #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       enable,
   input  logic       a_in,
   input  logic       b_in,
   output logic       step,
   output logic       up_down,
   output logic       err,
   output logic [3:0] err_count
);

   // The fill counter stops once every synchronizer stage holds a real sample.
   localparam logic [2:0] FILL_DONE = 3'(SYNC_STAGES);

   logic [SYNC_STAGES-1:0] r_syncA;
   logic [SYNC_STAGES-1:0] r_syncB;
   logic [1:0]             w_sync;
   logic [2:0]             r_fill;
   logic                   w_syncValid;
   logic [1:0]             w_state;

   logic [1:0]             r_prev;
   logic                   r_primed;
   logic                   r_step;
   logic                   r_upDown;
   logic                   r_err;
   logic [3:0]             r_errCount;

   logic                   w_changed;
   logic                   w_double;
   logic                   w_forward;

   // Shift each asynchronous phase through its own flop chain.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_syncA <= '0;
         r_syncB <= '0;
      end else begin
         r_syncA <= {r_syncA[SYNC_STAGES-2:0], a_in};
         r_syncB <= {r_syncB[SYNC_STAGES-2:0], b_in};
      end
   end

   assign w_sync = {r_syncA[SYNC_STAGES-1], r_syncB[SYNC_STAGES-1]};

   // Count edges after reset until the synchronizer output reflects the pins,
   // so priming never latches the cleared chain contents.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_fill <= '0;
      end else if (r_fill != FILL_DONE) begin
         r_fill <= r_fill + 3'd1;
      end
   end

   assign w_syncValid = (r_fill == FILL_DONE);

`ifdef QDEC_GLITCH_FILTER_EN
   localparam logic [3:0] CNT_LAST = 4'(FILTER_LEN - 1);

   logic [1:0] r_filt;
   logic [3:0] r_cntA;
   logic [3:0] r_cntB;
   logic [1:0] w_accept;

   // A phase flips on the FILTER_LEN-th consecutive differing sample; the
   // accepted state is formed combinationally so no extra edge is added.
   always_comb begin
      w_accept    = 2'b00;
      w_accept[1] = (w_sync[1] != r_filt[1]) && (r_cntA == CNT_LAST);
      w_accept[0] = (w_sync[0] != r_filt[0]) && (r_cntB == CNT_LAST);
      w_state     = (r_filt & ~w_accept) | (w_sync & w_accept);
   end

   // Per-phase stability counters; any reversion to the held level restarts
   // the count. Before priming the filter is seeded from the synchronizer.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_filt <= 2'b00;
         r_cntA <= '0;
         r_cntB <= '0;
      end else if (!r_primed) begin
         r_filt <= w_sync;
         r_cntA <= '0;
         r_cntB <= '0;
      end else begin
         if (w_sync[1] == r_filt[1]) begin
            r_cntA <= '0;
         end else if (w_accept[1]) begin
            r_filt[1] <= w_sync[1];
            r_cntA    <= '0;
         end else begin
            r_cntA <= r_cntA + 4'd1;
         end

         if (w_sync[0] == r_filt[0]) begin
            r_cntB <= '0;
         end else if (w_accept[0]) begin
            r_filt[0] <= w_sync[0];
            r_cntB    <= '0;
         end else begin
            r_cntB <= r_cntB + 4'd1;
         end
      end
   end
`else
   assign w_state = w_sync;
`endif

   // Classify the move from the previous accepted state to the current one.
   always_comb begin
      w_changed = (w_state != r_prev);
      w_double  = ((w_state ^ r_prev) == 2'b11);
      w_forward = 1'b0;
      case ({r_prev, w_state})
         4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: w_forward = 1'b1;
         default:                                 w_forward = 1'b0;
      endcase
   end

   // Prime on the first valid sample, then decode every accepted change into
   // a step or err pulse; direction updates even while decoding is disabled.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_prev     <= 2'b00;
         r_primed   <= 1'b0;
         r_step     <= 1'b0;
         r_upDown   <= 1'b1;
         r_err      <= 1'b0;
         r_errCount <= 4'd0;
      end else begin
         r_step <= 1'b0;
         r_err  <= 1'b0;
         if (!r_primed) begin
            if (w_syncValid) begin
               r_prev   <= w_sync;
               r_primed <= 1'b1;
            end
         end else if (w_changed) begin
            r_prev <= w_state;
            if (w_double) begin
               r_err <= enable;
               if (enable && (r_errCount != 4'hF)) begin
                  r_errCount <= r_errCount + 4'd1;
               end
            end else begin
               r_upDown <= w_forward;
               r_step   <= enable;
            end
         end
      end
   end

   assign step      = r_step;
   assign up_down   = r_upDown;
   assign err       = r_err;
   assign err_count = r_errCount;

endmodule

// File: tb/tb_quadrature_decoder.sv
// tb_quadrature_decoder
// Directed scenarios plus randomized encoder motion, checked every cycle
// against a history-based reference model of the decoder.
// Honours QDEC_GLITCH_FILTER_EN when the design is built with the filter.

module tb_quadrature_decoder;

   localparam int S = 2;
   localparam int F = 4;
`ifdef QDEC_GLITCH_FILTER_EN
   localparam int HOLD         = 8;
   localparam int LAT          = S + F;
   localparam int GLITCH_STEPS = 0;
`else
   localparam int HOLD         = 3;
   localparam int LAT          = S + 1;
   localparam int GLITCH_STEPS = 2;
`endif

   logic       clk     = 1'b0;
   logic       reset_n = 1'b0;
   logic       enable  = 1'b1;
   logic       a_in    = 1'b1;
   logic       b_in    = 1'b1;
   logic       step;
   logic       up_down;
   logic       err;
   logic [3:0] err_count;

   int testsRun    = 0;
   int testsFailed = 0;
   int stepSeen    = 0;
   int errSeen     = 0;
   bit checkEn     = 1'b0;

   // Reference model state
   logic [1:0] hist[$];
   int         mEdges  = 0;
   int         mView   = 0;
   bit         mAllNew = 1'b0;
   logic [1:0] mPrev   = 2'b00;
   logic [1:0] mAcc    = 2'b00;
   logic       mStep   = 1'b0;
   logic       mErr    = 1'b0;
   logic       mUp     = 1'b1;
   int         mErrCnt = 0;

   quadrature_decoder #(.SYNC_STAGES(S), .FILTER_LEN(F)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .enable    (enable),
      .a_in      (a_in),
      .b_in      (b_in),
      .step      (step),
      .up_down   (up_down),
      .err       (err),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   function automatic int grayPos(input logic [1:0] v);
      case (v)
         2'b00:   return 0;
         2'b10:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   function automatic logic [1:0] grayAt(input int p);
      case (p % 4)
         0:       return 2'b00;
         1:       return 2'b10;
         2:       return 2'b11;
         default: return 2'b01;
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] ab, input logic en, input int cycles);
      a_in   = ab[1];
      b_in   = ab[0];
      enable = en;
      repeat (cycles) @(negedge clk);
   endtask

   task automatic measureLatency(input logic [1:0] ab, output int lat);
      a_in = ab[1];
      b_in = ab[0];
      lat  = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         lat++;
         if (step) break;
      end
   endtask

   // Model: each accepted state is derived from the pin sample taken S edges
   // earlier; with the filter, a phase flips once its last F samples all differ.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hist.delete();
         mEdges  = 0;
         mStep   = 1'b0;
         mErr    = 1'b0;
         mUp     = 1'b1;
         mErrCnt = 0;
      end else begin
         hist.push_back({a_in, b_in});
         mEdges++;
         mStep = 1'b0;
         mErr  = 1'b0;
         if (mEdges == S + 1) begin
            mPrev = hist[0];
            mAcc  = hist[0];
         end else if (mEdges > S + 1) begin
            mView = mEdges - S - 1;
`ifdef QDEC_GLITCH_FILTER_EN
            for (int b = 0; b < 2; b++) begin
               mAllNew = 1'b1;
               for (int j = 0; j < F; j++) begin
                  if ((mView - j) < 0) mAllNew = 1'b0;
                  else if (hist[mView - j][b] == mAcc[b]) mAllNew = 1'b0;
               end
               if (mAllNew) mAcc[b] = ~mAcc[b];
            end
`else
            mAcc = hist[mView];
`endif
            if (mAcc != mPrev) begin
               if ((mAcc ^ mPrev) == 2'b11) begin
                  mErr = enable;
                  if (enable && mErrCnt < 15) mErrCnt++;
               end else begin
                  mUp   = (grayPos(mAcc) == (grayPos(mPrev) + 1) % 4);
                  mStep = enable;
               end
               mPrev = mAcc;
            end
         end
      end
   end

   // Compare every output against the model once per cycle, away from the edge.
   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("step", 32'(step), 32'(mStep));
         checkOutput("err", 32'(err), 32'(mErr));
         checkOutput("upDown", 32'(up_down), 32'(mUp));
         checkOutput("errCount", 32'(err_count), 32'(mErrCnt));
         checkOutput("exclusive", 32'(step & err), 32'd0);
         stepSeen += int'(step);
         errSeen  += int'(err);
      end
   end

   initial begin
      int         lat;
      int         base;
      int         baseErr;
      int         r;
      bit         gotStep;
      logic [1:0] cur;
      logic [1:0] nxt;

      repeat (3) @(negedge clk);
      checkEn = 1'b1;
      checkOutput("rstStep", 32'(step), 32'd0);
      checkOutput("rstUpDown", 32'(up_down), 32'd1);
      checkOutput("rstErrCount", 32'(err_count), 32'd0);

      // Prime with both phases high: nothing may fire.
      reset_n = 1'b1;
      applyStimulus(2'b11, 1'b1, 12);
      checkOutput("primeSteps", 32'(stepSeen), 32'd0);
      checkOutput("primeErrs", 32'(errSeen), 32'd0);
      checkOutput("primeUpDown", 32'(up_down), 32'd1);

      applyStimulus(2'b01, 1'b1, HOLD);
      applyStimulus(2'b00, 1'b1, 12);

      // Forward cycle
      base = stepSeen;
      measureLatency(2'b10, lat);
      checkOutput("fwdLatency", 32'(lat), 32'(LAT));
      applyStimulus(2'b10, 1'b1, HOLD - lat);
      applyStimulus(2'b11, 1'b1, HOLD);
      applyStimulus(2'b01, 1'b1, HOLD);
      applyStimulus(2'b00, 1'b1, 12);
      checkOutput("fwdSteps", 32'(stepSeen - base), 32'd4);
      checkOutput("fwdDir", 32'(up_down), 32'd1);

      // Reverse cycle
      base = stepSeen;
      applyStimulus(2'b01, 1'b1, HOLD);
      applyStimulus(2'b11, 1'b1, HOLD);
      applyStimulus(2'b10, 1'b1, HOLD);
      applyStimulus(2'b00, 1'b1, 12);
      checkOutput("revSteps", 32'(stepSeen - base), 32'd4);
      checkOutput("revDir", 32'(up_down), 32'd0);

      // Illegal double-bit jumps and counter saturation
      base    = stepSeen;
      baseErr = errSeen;
      applyStimulus(2'b11, 1'b1, 12);
      checkOutput("illegalErrs", 32'(errSeen - baseErr), 32'd1);
      checkOutput("illegalSteps", 32'(stepSeen - base), 32'd0);
      checkOutput("illegalCount", 32'(err_count), 32'd1);
      for (int i = 1; i < 20; i++) begin
         applyStimulus(((i % 2) == 1) ? 2'b00 : 2'b11, 1'b1, 12);
      end
      checkOutput("satErrs", 32'(errSeen - baseErr), 32'd20);
      checkOutput("satCount", 32'(err_count), 32'd15);

      // Short pulse on A, then a sustained level
      base = stepSeen;
      applyStimulus(2'b10, 1'b1, 2);
      applyStimulus(2'b00, 1'b1, 12);
      checkOutput("glitchSteps", 32'(stepSeen - base), 32'(GLITCH_STEPS));
      base = stepSeen;
      measureLatency(2'b10, lat);
      checkOutput("heldLatency", 32'(lat), 32'(LAT));
      applyStimulus(2'b10, 1'b1, 12);
      checkOutput("heldSteps", 32'(stepSeen - base), 32'd1);

      // Motion while disabled must not produce a step on re-enable
      applyStimulus(2'b00, 1'b1, 12);
      base    = stepSeen;
      baseErr = errSeen;
      applyStimulus(2'b10, 1'b0, HOLD);
      applyStimulus(2'b11, 1'b0, 12);
      checkOutput("disabledSteps", 32'(stepSeen - base), 32'd0);
      applyStimulus(2'b01, 1'b1, 12);
      checkOutput("reenableSteps", 32'(stepSeen - base), 32'd1);
      checkOutput("reenableDir", 32'(up_down), 32'd1);
      checkOutput("reenableErrs", 32'(errSeen - baseErr), 32'd0);

      // Random motion: mostly legal moves, some jumps, varying holds and enable
      cur = 2'b01;
      for (int i = 0; i < 300; i++) begin
         r = int'($urandom_range(0, 9));
         if (r < 4)      nxt = grayAt(grayPos(cur) + 1);
         else if (r < 8) nxt = grayAt(grayPos(cur) + 3);
         else if (r < 9) nxt = ~cur;
         else            nxt = cur;
         applyStimulus(nxt, ($urandom_range(0, 4) != 0), int'($urandom_range(1, 10)));
         cur = nxt;
      end

      // Reset asserted in the middle of a reverse step
      applyStimulus(cur, 1'b1, 12);
      nxt = grayAt(grayPos(cur) + 3);
      a_in    = nxt[1];
      b_in    = nxt[0];
      gotStep = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (step) begin
            gotStep = 1'b1;
            break;
         end
      end
      checkOutput("midStepSeen", 32'(gotStep), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("midRstStep", 32'(step), 32'd0);
      checkOutput("midRstUpDown", 32'(up_down), 32'd1);
      checkOutput("midRstErrCount", 32'(err_count), 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      base    = stepSeen;
      baseErr = errSeen;
      applyStimulus(nxt, 1'b1, 15);
      checkOutput("reprimeSteps", 32'(stepSeen - base), 32'd0);
      checkOutput("reprimeErrs", 32'(errSeen - baseErr), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
